// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length, clock-rate helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    // Host-to-device transmitter states
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAITIDLE,
        DONE
    } ps2_tx_state_e;

    // Start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    // Index of the parity bit in the driven bit sequence (data 0..7, then parity)
    localparam int PAR_IDX = FRAME_LEN - 3;

    // System clock cycles per microsecond
    function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus clock falling-edge detect.
// Latency: clk_s/data_s lag the pads by 2 cycles; fall is asserted in the cycle clk_s first reads low.
// Backpressure: none; free-running on every clock.
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_prev_q, clk_prev_d;

    // Shift the raw pads into the synchronizer chains and keep one history bit of the clock
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
    end

    // Idle PS/2 lines are high, so reset to high to avoid a spurious edge after reset
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 8 data + parity + stop, sample ack.
// Latency: line enables are registered; wr -> clock inhibit in 1 cycle, device fall -> data change in 3.
// Backpressure: wr is accepted only while busy is low; a wr during busy is dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned EDGE_TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    localparam int unsigned CPU       = cyc_per_us(CLK_HZ);
    localparam int unsigned N_INH     = CPU * INHIBIT_US;
    localparam int unsigned START_CYC = CPU * START_TIMEOUT_US;
    localparam int unsigned EDGE_CYC  = CPU * EDGE_TIMEOUT_US;
    localparam int          TW        = $clog2(START_CYC + 1);

    // Terminal timer values: the timer counts from 0, so the last cycle is limit-1
    localparam logic [TW-1:0] INH_LAST   = TW'(N_INH - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_CYC - 1);
    localparam logic [TW-1:0] EDGE_LAST  = TW'(EDGE_CYC - 1);
    localparam logic [3:0]    PAR_LAST   = 4'(PAR_IDX);

    ps2_tx_state_e   state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_q, bit_d;
    logic [8:0]      frame_q, frame_d;
    logic            nack_q, nack_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            clk_s, data_s, fall;
    logic            accept;

    ps2_line_sync u_sync (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    assign accept = wr & ~busy_q;

    // State, timer, frame and output registers; reset releases both lines asynchronously
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state: a fall always wins over a timer expiring in the same cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        frame_d = frame_q;
        nack_d  = nack_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                timer_d = '0;
            end
            INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    state_d = REQ;
                    timer_d = '0;
                end
            end
            REQ: begin
                // First device fall: bit 0 goes out as SHIFT is entered
                if (fall) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    timer_d = '0;
                end else if (timer_q == START_LAST) begin
                    state_d = DONE;
                    nack_d  = 1'b1;
                end
            end
            SHIFT: begin
                // The fall after parity releases data, which is the stop bit
                if (fall) begin
                    timer_d = '0;
                    if (bit_q == PAR_LAST) begin
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else if (timer_q == EDGE_LAST) begin
                    state_d = DONE;
                    nack_d  = 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    state_d = WAITIDLE;
                    nack_d  = data_s;
                end else if (timer_q == EDGE_LAST) begin
                    state_d = DONE;
                    nack_d  = 1'b1;
                end
            end
            WAITIDLE: begin
                if (clk_s && data_s) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // New command: capture byte with odd parity and restart from inhibit
        if (accept) begin
            state_d = INHIBIT;
            timer_d = '0;
            bit_d   = '0;
            frame_d = {~^wdata, wdata};
            nack_d  = 1'b0;
        end
    end

    // Outputs decoded from the next state so the line enables come straight from flops
    always_comb begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        unique case (state_d)
            IDLE: busy_d = 1'b0;
            INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = (timer_d == INH_LAST);
            end
            REQ:   data_oe_d = 1'b1;
            SHIFT: data_oe_d = ~frame_d[bit_d];
            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nack        = nack_q;

endmodule
